zynq_aes_arb: RTL and testbench
===============================

ZYNQ_AES_ARB -- requirements
Module: zynq_aes_arb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the AXI-Stream word width on all six stream interfaces.
REQ-002 Parameter ORDER_DEPTH, default 4, SHALL set the depth of the response-order FIFO (power of two, >=2).
REQ-003 aclk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 s0_axis_tdata/tlast/tvalid  in  DATA_W/1/1  request stream from requester 0; s0_axis_tready  out  1.
REQ-006 s1_axis_tdata/tlast/tvalid  in  DATA_W/1/1  request stream from requester 1; s1_axis_tready  out  1.
REQ-007 core_in_tdata/tlast/tvalid  out  DATA_W/1/1  request stream to the AES core; core_in_tready  in  1.
REQ-008 core_out_tdata/tlast/tvalid  in  DATA_W/1/1  result stream from the AES core; core_out_tready  out  1.
REQ-009 m0_axis_tdata/tlast/tvalid  out  DATA_W/1/1  results to requester 0; m0_axis_tready  in  1.
REQ-010 m1_axis_tdata/tlast/tvalid  out  DATA_W/1/1  results to requester 1; m1_axis_tready  in  1.
REQ-011 grant  out  2  one-hot current input grant (bit0 = requester 0); 0 when idle.
REQ-012 pending  out  $clog2(ORDER_DEPTH)+1  number of packets granted but whose result tlast has not yet left.

Function
REQ-013 Packet = words up to and including the word with tlast=1; arbitration granularity SHALL be whole packets, never interleaved.
REQ-014 Input FSM states: IDLE, XFER; in IDLE, grant=0 and all s*_axis_tready=0.
REQ-015 IDLE->XFER on the cycle when at least one s*_axis_tvalid=1 and the order FIFO is not full; winner registered into grant, its index pushed into the order FIFO on the same edge.
REQ-016 Winner selection: single requester -> that one; both -> requester other than last_winner (round-robin); last_winner updated at grant.
REQ-017 In XFER: core_in_* SHALL be a combinational pass-through of the granted s*_axis_* data/tlast/tvalid, granted s*_axis_tready = core_in_tready, other tready=0.
REQ-018 XFER->IDLE on core_in handshake with tlast=1; minimum one IDLE (bubble) cycle between packets.
REQ-019 Order FIFO full in IDLE: SHALL stay IDLE, no grant, no push, until a pop frees an entry.
REQ-020 Output side: FIFO non-empty -> core_out_* routed to m[head]_axis_*, core_out_tready = m[head]_axis_tready, other m*_axis_tvalid=0.
REQ-021 FIFO empty: core_out_tready=0, m0/m1_axis_tvalid=0.
REQ-022 Pop on core_out handshake with tlast=1; routing switches to new head the following cycle.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo ORDER_DEPTH.
REQ-024 pending SHALL equal FIFO occupancy, updated on the same edge as push/pop.
REQ-025 core_in_tvalid SHALL not depend on core_in_tready; no output tvalid drops while stalled except through source tvalid.

Reset
REQ-026 aresetn=0 on a rising edge: FSM=IDLE, grant=0, FIFO empty, pending=0, last_winner=1 (requester 0 wins first tie), all tready/tvalid outputs 0 while reset is asserted.
REQ-027 Reset mid-packet SHALL abandon in-flight packets; no state retained; core reset is the system's responsibility.

Verification
REQ-028 Both requesters assert tvalid with 4-word packets (tlast on word 4), all readies 1 -> grant sequence 01,10,01,10; one idle cycle between packets; pending peaks <=2.
REQ-029 Only s1 valid, 8-word packet, core_in_tready toggling 2 low/6 high -> all 8 words reach core_in in order, s0_axis_tready=0 throughout.
REQ-030 Core returns results late: push 4 packets (s0,s1,s0,s1) with core_out_tready withheld -> pending=4, 5th request not granted; first result tlast pops -> 5th granted next IDLE cycle.
REQ-031 Results for order s1,s0: core_out words 0xA0..0xA3 then 0xB0..0xB3 -> 0xA* appear only on m1, 0xB* only on m0; m0_axis_tready=0 stalls core_out_tready.
REQ-032 aresetn=0 during word 2 of a 4-word packet -> next cycle grant=0, pending=0, all tready/tvalid 0; after release, tie goes to requester 0.

Source files
------------

// File: rtl/zynq_aes_arb.sv
// zynq_aes_arb: shares one AES core between two AXI-Stream requesters.
// Whole request packets are arbitrated round-robin. A small order FIFO
// records which requester owns each packet in flight, so that core results
// are returned to the requester that sent the matching request.
module zynq_aes_arb #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ORDER_DEPTH = 4
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   // requester 0 request stream
   input  logic [DATA_W-1:0]            s0_axis_tdata,
   input  logic                         s0_axis_tlast,
   input  logic                         s0_axis_tvalid,
   output logic                         s0_axis_tready,
   // requester 1 request stream
   input  logic [DATA_W-1:0]            s1_axis_tdata,
   input  logic                         s1_axis_tlast,
   input  logic                         s1_axis_tvalid,
   output logic                         s1_axis_tready,
   // request stream to the core
   output logic [DATA_W-1:0]            core_in_tdata,
   output logic                         core_in_tlast,
   output logic                         core_in_tvalid,
   input  logic                         core_in_tready,
   // result stream from the core
   input  logic [DATA_W-1:0]            core_out_tdata,
   input  logic                         core_out_tlast,
   input  logic                         core_out_tvalid,
   output logic                         core_out_tready,
   // results to requester 0
   output logic [DATA_W-1:0]            m0_axis_tdata,
   output logic                         m0_axis_tlast,
   output logic                         m0_axis_tvalid,
   input  logic                         m0_axis_tready,
   // results to requester 1
   output logic [DATA_W-1:0]            m1_axis_tdata,
   output logic                         m1_axis_tlast,
   output logic                         m1_axis_tvalid,
   input  logic                         m1_axis_tready,
   // status
   output logic [1:0]                   grant,
   output logic [$clog2(ORDER_DEPTH):0] pending
);

   localparam int unsigned PTR_W = $clog2(ORDER_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      S_IDLE,
      S_XFER
   } state_e;

   state_e                   state_q, state_d;
   logic [1:0]               grant_q, grant_d;
   logic                     last_q, last_d;     // index of the last winner
   logic [ORDER_DEPTH-1:0]   order_q, order_d;   // owner index per FIFO slot
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;

   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     head;
   logic                     push;
   logic                     pop;
   logic                     win;
   logic                     xfer;
   logic                     cin_done;
   logic                     route;

   assign fifo_full  = (count_q == CNT_W'(ORDER_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head       = order_q[rd_ptr_q];
   assign xfer       = (state_q == S_XFER) && aresetn;
   assign route      = !fifo_empty && aresetn;
   assign cin_done   = core_in_tvalid && core_in_tready && core_in_tlast;
   assign pop        = core_out_tvalid && core_out_tready && core_out_tlast;

   assign grant   = grant_q;
   assign pending = count_q;

   // Request path: granted requester is passed straight through to the core
   always_comb begin
      core_in_tdata  = grant_q[1] ? s1_axis_tdata : s0_axis_tdata;
      core_in_tlast  = grant_q[1] ? s1_axis_tlast : s0_axis_tlast;
      core_in_tvalid = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (xfer) begin
         core_in_tvalid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
         s0_axis_tready = grant_q[0] && core_in_tready;
         s1_axis_tready = grant_q[1] && core_in_tready;
      end
   end

   // Result path: core output is steered to the requester at the FIFO head
   always_comb begin
      m0_axis_tdata   = core_out_tdata;
      m0_axis_tlast   = core_out_tlast;
      m1_axis_tdata   = core_out_tdata;
      m1_axis_tlast   = core_out_tlast;
      m0_axis_tvalid  = 1'b0;
      m1_axis_tvalid  = 1'b0;
      core_out_tready = 1'b0;
      if (route) begin
         m0_axis_tvalid  = !head && core_out_tvalid;
         m1_axis_tvalid  = head && core_out_tvalid;
         core_out_tready = head ? m1_axis_tready : m0_axis_tready;
      end
   end

   // Input FSM: pick a winner in IDLE, hold the grant until its tlast passes
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      push    = 1'b0;
      win     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((s0_axis_tvalid || s1_axis_tvalid) && !fifo_full) begin
               // on a tie the requester that did not win last time goes next
               win     = (s0_axis_tvalid && s1_axis_tvalid) ? !last_q : s1_axis_tvalid;
               grant_d = win ? 2'b10 : 2'b01;
               last_d  = win;
               push    = 1'b1;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (cin_done) begin
               grant_d = 2'b00;
               state_d = S_IDLE;
            end
         end
         default: begin
            grant_d = 2'b00;
            state_d = S_IDLE;
         end
      endcase
   end

   // Order FIFO bookkeeping: push on grant, pop on result tlast
   always_comb begin
      order_d  = order_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         order_d[wr_ptr_q] = win;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         grant_q  <= 2'b00;
         last_q   <= 1'b1;
         order_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         order_q  <= order_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_zynq_aes_arb.sv
// Bench for zynq_aes_arb: a cycle-driven environment models two requesters,
// the AES core (word-wise XOR with a key, FIFO order) and two result sinks.
// Expected results are the requesters' own packets, in order, per requester.
module tb_zynq_aes_arb;

   localparam int unsigned DW = 32;
   localparam int unsigned OD = 4;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } word_t;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, core_in_tdata, core_out_tdata;
   logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
   logic          s0_axis_tlast, s0_axis_tvalid, s0_axis_tready;
   logic          s1_axis_tlast, s1_axis_tvalid, s1_axis_tready;
   logic          core_in_tlast, core_in_tvalid, core_in_tready;
   logic          core_out_tlast, core_out_tvalid, core_out_tready;
   logic          m0_axis_tlast, m0_axis_tvalid, m0_axis_tready;
   logic          m1_axis_tlast, m1_axis_tvalid, m1_axis_tready;
   logic [1:0]    grant;
   logic [2:0]    pending;

   always #5 aclk = ~aclk;

   zynq_aes_arb #(.DATA_W(DW), .ORDER_DEPTH(OD)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tlast(s0_axis_tlast),
      .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tlast(s1_axis_tlast),
      .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
      .core_in_tdata(core_in_tdata), .core_in_tlast(core_in_tlast),
      .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready),
      .core_out_tdata(core_out_tdata), .core_out_tlast(core_out_tlast),
      .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
      .m0_axis_tdata(m0_axis_tdata), .m0_axis_tlast(m0_axis_tlast),
      .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
      .m1_axis_tdata(m1_axis_tdata), .m1_axis_tlast(m1_axis_tlast),
      .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
      .grant(grant), .pending(pending)
   );

   // environment state
   word_t      src0_q[$], src1_q[$], core_q[$], cin_log[$];
   word_t      rx0[$], rx1[$], exp0[$], exp1[$];
   logic [1:0] grant_log[$];
   int         grant_cyc[$];
   int         n_pass, n_total, cyc;
   int         p_sv, p_cin, p_cout, p_m0, p_m1;
   bit         cin_pat, core_hold, v0, v1, vc, prev_cin_last;
   bit         s0_rdy_seen, cout_rdy_seen;
   logic [DW-1:0] core_key;
   logic [1:0] prev_grant;
   int         bubble_err, dual_err, pend_err, pend_max;
   int         n_grants, n_pops, n_sh0, first_pop_cyc;
   logic [1:0] snap_grant;
   logic [2:0] snap_pend;
   logic [5:0] snap_ctl;

   function automatic bit roll(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   task automatic env_clear();
      src0_q.delete(); src1_q.delete(); core_q.delete(); cin_log.delete();
      rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
      grant_log.delete(); grant_cyc.delete();
      v0 = 0; v1 = 0; vc = 0; prev_cin_last = 0; prev_grant = 2'b00;
      s0_rdy_seen = 0; cout_rdy_seen = 0;
      bubble_err = 0; dual_err = 0; pend_err = 0; pend_max = 0;
      n_grants = 0; n_pops = 0; n_sh0 = 0; first_pop_cyc = -1;
      p_sv = 100; p_cin = 100; p_cout = 100; p_m0 = 100; p_m1 = 100;
      cin_pat = 0; core_hold = 0; core_key = '0;
   endtask

   // one packet of len words base, base+1, ...; expected result is word ^ key
   task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base);
      word_t w, e;
      for (int i = 0; i < len; i++) begin
         w.d = base + DW'(i);
         w.l = (i == len - 1);
         e   = w;
         e.d = w.d ^ core_key;
         if (src == 0) begin src0_q.push_back(w); exp0.push_back(e); end
         else          begin src1_q.push_back(w); exp1.push_back(e); end
      end
   endtask

   task automatic env_drive();
      if (src0_q.size() == 0) v0 = 0; else if (!v0 && roll(p_sv)) v0 = 1;
      if (src1_q.size() == 0) v1 = 0; else if (!v1 && roll(p_sv)) v1 = 1;
      s0_axis_tvalid = v0;
      s0_axis_tdata  = (src0_q.size() > 0) ? src0_q[0].d : '0;
      s0_axis_tlast  = (src0_q.size() > 0) ? src0_q[0].l : 1'b0;
      s1_axis_tvalid = v1;
      s1_axis_tdata  = (src1_q.size() > 0) ? src1_q[0].d : '0;
      s1_axis_tlast  = (src1_q.size() > 0) ? src1_q[0].l : 1'b0;
      core_in_tready = cin_pat ? ((cyc % 8) >= 2) : roll(p_cin);
      if (core_hold || core_q.size() == 0) vc = 0; else if (!vc && roll(p_cout)) vc = 1;
      core_out_tvalid = vc;
      core_out_tdata  = (core_q.size() > 0) ? (core_q[0].d ^ core_key) : '0;
      core_out_tlast  = (core_q.size() > 0) ? core_q[0].l : 1'b0;
      m0_axis_tready  = roll(p_m0);
      m1_axis_tready  = roll(p_m1);
   endtask

   task automatic env_sample();
      word_t w;
      snap_grant = grant;
      snap_pend  = pending;
      snap_ctl   = {s0_axis_tready, s1_axis_tready, core_in_tvalid,
                    core_out_tready, m0_axis_tvalid, m1_axis_tvalid};
      if (aresetn) begin
         if (grant != 2'b00 && prev_grant == 2'b00) begin
            grant_log.push_back(grant); grant_cyc.push_back(cyc); n_grants++;
         end
         if (prev_cin_last && grant != 2'b00) bubble_err++;
         if (int'(pending) != n_grants - n_pops) pend_err++;
         if (int'(pending) > pend_max) pend_max = int'(pending);
         if (m0_axis_tvalid && m1_axis_tvalid) dual_err++;
      end
      prev_grant    = grant;
      prev_cin_last = core_in_tvalid && core_in_tready && core_in_tlast;
      s0_rdy_seen   = s0_rdy_seen || s0_axis_tready;
      cout_rdy_seen = cout_rdy_seen || core_out_tready;
      if (s0_axis_tvalid && s0_axis_tready) begin void'(src0_q.pop_front()); v0 = 0; n_sh0++; end
      if (s1_axis_tvalid && s1_axis_tready) begin void'(src1_q.pop_front()); v1 = 0; end
      if (core_out_tvalid && core_out_tready) begin
         if (core_out_tlast) begin
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
         end
         void'(core_q.pop_front()); vc = 0;
      end
      if (core_in_tvalid && core_in_tready) begin
         w.d = core_in_tdata; w.l = core_in_tlast;
         core_q.push_back(w); cin_log.push_back(w);
      end
      if (m0_axis_tvalid && m0_axis_tready) begin
         w.d = m0_axis_tdata; w.l = m0_axis_tlast; rx0.push_back(w);
      end
      if (m1_axis_tvalid && m1_axis_tready) begin
         w.d = m1_axis_tdata; w.l = m1_axis_tlast; rx1.push_back(w);
      end
      cyc++;
   endtask

   // called at a rising edge; drives after it, samples on the falling edge
   task automatic env_cycle();
      #1 env_drive();
      @(negedge aclk);
      env_sample();
      @(posedge aclk);
   endtask

   task automatic set_rst(input logic v);
      #1 aresetn = v;
   endtask

   task automatic do_reset();
      set_rst(1'b0);
      env_clear();
      repeat (2) env_cycle();
      set_rst(1'b1);
      env_clear();
   endtask

   task automatic test_reset();
      set_rst(1'b0);
      env_clear();
      add_pkt(0, 1, 32'h0000_0010);
      repeat (3) env_cycle();
      n_total++;
      if (snap_grant !== 2'b00) $display("FAIL reset_grant got %b exp 00", snap_grant);
      else n_pass++;
      n_total++;
      if (snap_pend !== 3'd0) $display("FAIL reset_pending got %0d exp 0", snap_pend);
      else n_pass++;
      n_total++;
      if (snap_ctl !== 6'b0) $display("FAIL reset_ready_valid got %b exp 000000", snap_ctl);
      else n_pass++;
      n_total++;
      if (src0_q.size() != 1) $display("FAIL reset_no_accept got %0d exp 1", src0_q.size());
      else n_pass++;
      set_rst(1'b1);
      env_clear();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g[4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      core_key = 32'h5A5A_0000;
      add_pkt(0, 4, 32'h100); add_pkt(0, 4, 32'h110);
      add_pkt(1, 4, 32'h200); add_pkt(1, 4, 32'h210);
      for (int i = 0; i < 200 && (rx0.size() < 8 || rx1.size() < 8); i++) env_cycle();
      n_total++;
      if (rx0.size() != 8 || rx1.size() != 8)
         $display("FAIL rr_timeout got %0d/%0d words exp 8/8", rx0.size(), rx1.size());
      else n_pass++;
      n_total++;
      if (grant_log.size() != 4) $display("FAIL rr_grant_count got %0d exp 4", grant_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (i >= grant_log.size()) $display("FAIL rr_grant[%0d] missing exp %b", i, exp_g[i]);
         else if (grant_log[i] !== exp_g[i])
            $display("FAIL rr_grant[%0d] got %b exp %b", i, grant_log[i], exp_g[i]);
         else n_pass++;
      end
      n_total++;
      if (bubble_err != 0) $display("FAIL rr_bubble got %0d violations exp 0", bubble_err);
      else n_pass++;
      n_total++;
      if (pend_max > 2) $display("FAIL rr_pending_peak got %0d exp <=2", pend_max);
      else n_pass++;
      n_total++;
      if (pend_err != 0) $display("FAIL rr_pending_track got %0d errors exp 0", pend_err);
      else n_pass++;
      for (int i = 0; i < exp0.size(); i++) begin
         n_total++;
         if (i >= rx0.size()) $display("FAIL rr_m0[%0d] missing exp %h", i, exp0[i]);
         else if (rx0[i] !== exp0[i]) $display("FAIL rr_m0[%0d] got %h exp %h", i, rx0[i], exp0[i]);
         else n_pass++;
      end
      for (int i = 0; i < exp1.size(); i++) begin
         n_total++;
         if (i >= rx1.size()) $display("FAIL rr_m1[%0d] missing exp %h", i, exp1[i]);
         else if (rx1[i] !== exp1[i]) $display("FAIL rr_m1[%0d] got %h exp %h", i, rx1[i], exp1[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stream_stall();
      do_reset();
      cin_pat = 1;
      add_pkt(1, 8, 32'h300);
      for (int i = 0; i < 150 && rx1.size() < 8; i++) env_cycle();
      n_total++;
      if (cin_log.size() != 8) $display("FAIL stall_core_words got %0d exp 8", cin_log.size());
      else n_pass++;
      for (int i = 0; i < exp1.size(); i++) begin
         n_total++;
         if (i >= cin_log.size()) $display("FAIL stall_core_in[%0d] missing exp %h", i, exp1[i]);
         else if (cin_log[i] !== exp1[i])
            $display("FAIL stall_core_in[%0d] got %h exp %h", i, cin_log[i], exp1[i]);
         else n_pass++;
      end
      n_total++;
      if (s0_rdy_seen) $display("FAIL stall_s0_tready got 1 exp 0");
      else n_pass++;
      n_total++;
      if (rx1.size() != 8) $display("FAIL stall_m1_words got %0d exp 8", rx1.size());
      else n_pass++;
   endtask

   task automatic test_order_full();
      logic [7:0] gseq;
      do_reset();
      core_key  = 32'hC0DE_0000;
      core_hold = 1;
      add_pkt(0, 2, 32'h400); add_pkt(1, 2, 32'h500);
      add_pkt(0, 2, 32'h410); add_pkt(1, 2, 32'h510);
      add_pkt(0, 2, 32'h420);
      repeat (20) env_cycle();
      n_total++;
      if (snap_pend !== 3'd4) $display("FAIL full_pending got %0d exp 4", snap_pend);
      else n_pass++;
      n_total++;
      if (snap_grant !== 2'b00) $display("FAIL full_no_grant got %b exp 00", snap_grant);
      else n_pass++;
      n_total++;
      if (src0_q.size() != 2) $display("FAIL full_5th_held got %0d words left exp 2", src0_q.size());
      else n_pass++;
      gseq = '0;
      for (int i = 0; i < 4 && i < grant_log.size(); i++) gseq[7-2*i -: 2] = grant_log[i];
      n_total++;
      if (grant_log.size() != 4 || gseq !== 8'b01_10_01_10)
         $display("FAIL full_grant_seq got %b (%0d grants) exp 01100110", gseq, grant_log.size());
      else n_pass++;
      core_hold = 0;
      for (int i = 0; i < 50 && grant_log.size() < 5; i++) env_cycle();
      n_total++;
      if (grant_log.size() != 5 || grant_log[4] !== 2'b01 || grant_cyc[4] != first_pop_cyc + 2)
         $display("FAIL full_5th_grant got %0d grants, pop cyc %0d exp grant 01 at pop+2",
                  grant_log.size(), first_pop_cyc);
      else n_pass++;
      for (int i = 0; i < 100 && (rx0.size() < 6 || rx1.size() < 4); i++) env_cycle();
      for (int i = 0; i < exp0.size(); i++) begin
         n_total++;
         if (i >= rx0.size()) $display("FAIL full_m0[%0d] missing exp %h", i, exp0[i]);
         else if (rx0[i] !== exp0[i]) $display("FAIL full_m0[%0d] got %h exp %h", i, rx0[i], exp0[i]);
         else n_pass++;
      end
      for (int i = 0; i < exp1.size(); i++) begin
         n_total++;
         if (i >= rx1.size()) $display("FAIL full_m1[%0d] missing exp %h", i, exp1[i]);
         else if (rx1[i] !== exp1[i]) $display("FAIL full_m1[%0d] got %h exp %h", i, rx1[i], exp1[i]);
         else n_pass++;
      end
   endtask

   task automatic test_routing();
      do_reset();
      p_m0 = 0;
      add_pkt(1, 4, 32'hA0);
      for (int i = 0; i < 10 && grant_log.size() < 1; i++) env_cycle();
      add_pkt(0, 4, 32'hB0);
      for (int i = 0; i < 60 && rx1.size() < 4; i++) env_cycle();
      repeat (3) env_cycle();
      cout_rdy_seen = 0;
      repeat (5) env_cycle();
      n_total++;
      if (rx0.size() != 0) $display("FAIL route_m0_stalled got %0d words exp 0", rx0.size());
      else n_pass++;
      n_total++;
      if (cout_rdy_seen) $display("FAIL route_core_out_tready got 1 exp 0");
      else n_pass++;
      n_total++;
      if (core_q.size() != 4) $display("FAIL route_core_held got %0d exp 4", core_q.size());
      else n_pass++;
      p_m0 = 100;
      for (int i = 0; i < 60 && rx0.size() < 4; i++) env_cycle();
      n_total++;
      if (rx1.size() != 4) $display("FAIL route_m1_count got %0d exp 4", rx1.size());
      else n_pass++;
      for (int i = 0; i < exp1.size(); i++) begin
         n_total++;
         if (i >= rx1.size()) $display("FAIL route_m1[%0d] missing exp %h", i, exp1[i]);
         else if (rx1[i] !== exp1[i]) $display("FAIL route_m1[%0d] got %h exp %h", i, rx1[i], exp1[i]);
         else n_pass++;
      end
      for (int i = 0; i < exp0.size(); i++) begin
         n_total++;
         if (i >= rx0.size()) $display("FAIL route_m0[%0d] missing exp %h", i, exp0[i]);
         else if (rx0[i] !== exp0[i]) $display("FAIL route_m0[%0d] got %h exp %h", i, rx0[i], exp0[i]);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      core_hold = 1;
      add_pkt(0, 4, 32'h600);
      for (int i = 0; i < 20 && n_sh0 < 1; i++) env_cycle();
      set_rst(1'b0);
      env_cycle();
      env_cycle();
      n_total++;
      if (snap_grant !== 2'b00) $display("FAIL midrst_grant got %b exp 00", snap_grant);
      else n_pass++;
      n_total++;
      if (snap_pend !== 3'd0) $display("FAIL midrst_pending got %0d exp 0", snap_pend);
      else n_pass++;
      n_total++;
      if (snap_ctl !== 6'b0) $display("FAIL midrst_ready_valid got %b exp 000000", snap_ctl);
      else n_pass++;
      set_rst(1'b1);
      env_clear();
      add_pkt(0, 1, 32'h700);
      add_pkt(1, 1, 32'h710);
      for (int i = 0; i < 10 && grant_log.size() < 1; i++) env_cycle();
      n_total++;
      if (grant_log.size() < 1 || grant_log[0] !== 2'b01)
         $display("FAIL midrst_tie got %0d grants exp first 01", grant_log.size());
      else n_pass++;
      for (int i = 0; i < 40 && (rx0.size() < 1 || rx1.size() < 1); i++) env_cycle();
   endtask

   task automatic test_random();
      do_reset();
      core_key = $urandom;
      p_sv = 70; p_cin = 60; p_cout = 60; p_m0 = 70; p_m1 = 70;
      for (int k = 0; k < 6; k++) begin
         add_pkt(0, int'($urandom_range(5, 1)), $urandom);
         add_pkt(1, int'($urandom_range(5, 1)), $urandom);
      end
      for (int i = 0; i < 3000 && (rx0.size() < exp0.size() || rx1.size() < exp1.size()); i++)
         env_cycle();
      n_total++;
      if (rx0.size() != exp0.size() || rx1.size() != exp1.size())
         $display("FAIL rand_timeout got %0d/%0d words exp %0d/%0d",
                  rx0.size(), rx1.size(), exp0.size(), exp1.size());
      else n_pass++;
      for (int i = 0; i < exp0.size(); i++) begin
         n_total++;
         if (i >= rx0.size()) $display("FAIL rand_m0[%0d] missing exp %h", i, exp0[i]);
         else if (rx0[i] !== exp0[i]) $display("FAIL rand_m0[%0d] got %h exp %h", i, rx0[i], exp0[i]);
         else n_pass++;
      end
      for (int i = 0; i < exp1.size(); i++) begin
         n_total++;
         if (i >= rx1.size()) $display("FAIL rand_m1[%0d] missing exp %h", i, exp1[i]);
         else if (rx1[i] !== exp1[i]) $display("FAIL rand_m1[%0d] got %h exp %h", i, rx1[i], exp1[i]);
         else n_pass++;
      end
      n_total++;
      if (dual_err != 0) $display("FAIL rand_dual_valid got %0d exp 0", dual_err);
      else n_pass++;
      n_total++;
      if (bubble_err != 0) $display("FAIL rand_bubble got %0d exp 0", bubble_err);
      else n_pass++;
      n_total++;
      if (pend_err != 0) $display("FAIL rand_pending_track got %0d errors exp 0", pend_err);
      else n_pass++;
      n_total++;
      if (pend_max > int'(OD)) $display("FAIL rand_pending_peak got %0d exp <=%0d", pend_max, OD);
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0; cyc = 0;
      aresetn = 1'b0;
      s0_axis_tdata = '0; s0_axis_tlast = 0; s0_axis_tvalid = 0;
      s1_axis_tdata = '0; s1_axis_tlast = 0; s1_axis_tvalid = 0;
      core_in_tready = 0; core_out_tdata = '0; core_out_tlast = 0; core_out_tvalid = 0;
      m0_axis_tready = 0; m1_axis_tready = 0;
      env_clear();
      @(posedge aclk);
      test_reset();
      test_round_robin();
      test_stream_stall();
      test_order_full();
      test_routing();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
